route_arbiter: RTL and testbench
================================

ROUTE_ARBITER -- requirements
Module: route_arbiter

Interface
REQ-001 Parameter FLAG, default 16'hF1A6, value driven on flag_led once any requester has solved the route.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  per-requester request, level, held until done.
REQ-005 status_bus  input  64  requester i status word on [16i+15:16i].
REQ-006 cfg_we  input  1  route-table write strobe.
REQ-007 cfg_addr  input  3  route-table step index.
REQ-008 cfg_action  input  2  route-table entry value.
REQ-009 gnt  output  4  one-hot grant, registered.
REQ-010 done  output  4  one-cycle result pulse for requester i.
REQ-011 pass  output  4  result bit; valid only with done.
REQ-012 solved  output  4  sticky per-requester solved flags.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 flag_led  output  16  FLAG when solved != 0, else 16'h0000.

Function
REQ-015 FSM states IDLE, GRANT, SCAN, REPORT; all outputs registered.
REQ-016 IDLE with req != 0: select next requester round-robin, starting at (last_served+1) mod 4; go to GRANT; gnt bit set entering GRANT.
REQ-017 GRANT (1 cycle): capture selected 16-bit status word into a shadow register; go to SCAN with step = 0.
REQ-018 SCAN (exactly 8 cycles, step 0..7): decode field status[15-2*step : 14-2*step], MSB pair first.
REQ-019 Field decode: 00 -> 2'b01 wander; 01 -> 2'b10 evade; 10 -> 2'b11 first_aid; 11 -> 2'b00 idle.
REQ-020 Each step: mismatch flag |= (decoded action != route[step]); no early abort, scan is always 8 cycles.
REQ-021 REPORT (1 cycle): done[id]=1, pass[id]=!mismatch, solved[id] |= pass; gnt cleared; last_served = id; next state IDLE.
REQ-022 Latency: req seen in IDLE at cycle t -> gnt at t+1, capture at t+1, scan t+2..t+9, done at t+10, IDLE at t+11.
REQ-023 Requester holding req after its done is re-eligible, lowest round-robin priority.
REQ-024 req deasserted during GRANT/SCAN: scan completes and REPORT still issued for that requester.
REQ-025 status_bus changes after GRANT have no effect on the current scan.
REQ-026 Route table: 8 x 2-bit; cfg_we written only in IDLE and only in a cycle where no grant is issued; ignored otherwise.
REQ-027 cfg_we and req in same IDLE cycle: grant issued, write dropped.
REQ-028 done, pass zero in all cycles except REPORT; gnt zero in IDLE.

Reset
REQ-029 rst low at a clock edge: state IDLE, gnt=0, done=0, pass=0, solved=0, busy=0, flag_led=0, step=0, mismatch=0.
REQ-030 Reset sets last_served=3 so requester 0 has first priority.
REQ-031 Reset loads every route entry with 2'b01 (wander).
REQ-032 Reset during GRANT/SCAN/REPORT aborts the transaction; no done pulse is issued for it.

Verification
REQ-033 Reset, req=4'b0001, status0=16'h0000 -> gnt=0001 at t+1, done[0]=1 and pass[0]=1 at t+10, solved=0001, flag_led=16'hF1A6 from t+11.
REQ-034 Program route {10,10,01,10,11,01,01,11} for steps 0..7; status0=16'h5182 -> pass[0]=1; status0=16'h5183 -> pass[0]=0, solved unchanged.
REQ-035 req=4'b1111 held -> grants in order 0,1,2,3,0, one every 11 cycles, each done paired with the matching bit.
REQ-036 cfg_we pulse during SCAN with cfg_addr=0, cfg_action=00 -> route[0] unchanged; the same write in IDLE with req=0 -> route[0]=00.
REQ-037 rst low at step 4 of SCAN -> all outputs zero next cycle, no done, solved=0; request re-served from IDLE after rst high.

Source files
------------

// File: rtl/route_arbiter.sv
`default_nettype none
// route_arbiter: round-robin arbiter that scans a granted requester's status word against a route table.
// Rev 1.0

module route_arbiter #(
   parameter logic [15:0] FLAG = 16'hF1A6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [63:0] status_bus,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_addr,
   input  logic [1:0]  cfg_action,
   output logic [3:0]  gnt,
   output logic [3:0]  done,
   output logic [3:0]  pass,
   output logic [3:0]  solved,
   output logic        busy,
   output logic [15:0] flag_led
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT  = 2'd1,
      S_SCAN   = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   state_t      state_q;
   logic [1:0]  id_q;
   logic [1:0]  last_q;
   logic [15:0] shadow_q;
   logic [2:0]  step_q;
   logic        mismatch_q;
   logic [1:0]  route_q [8];
   logic [3:0]  gnt_q;
   logic [3:0]  done_q;
   logic [3:0]  pass_q;
   logic [3:0]  solved_q;
   logic        busy_q;
   logic [15:0] flag_q;

   logic        sel_valid_d;
   logic [1:0]  sel_id_d;
   logic [3:0]  field_base_d;
   logic [1:0]  field_d;
   logic [1:0]  act_d;
   logic        mismatch_d;
   logic [3:0]  id_onehot_d;
   logic [3:0]  solved_d;

   // Search starts just after the last served requester, so it has lowest priority.
   always_comb begin
      sel_valid_d = 1'b0;
      sel_id_d    = last_q;
      for (int k = 1; k <= 4; k++) begin
         if (!sel_valid_d && req[last_q + 2'(k)]) begin
            sel_valid_d = 1'b1;
            sel_id_d    = last_q + 2'(k);
         end
      end
   end

   always_comb begin
      field_base_d = 4'd15 - {step_q, 1'b0};
      field_d      = shadow_q[field_base_d -: 2];
      case (field_d)
         2'b00:   act_d = 2'b01;
         2'b01:   act_d = 2'b10;
         2'b10:   act_d = 2'b11;
         default: act_d = 2'b00;
      endcase
      mismatch_d  = mismatch_q | (act_d != route_q[step_q]);
      id_onehot_d = 4'b0001 << id_q;
      solved_d    = solved_q | (mismatch_d ? 4'b0000 : id_onehot_d);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         id_q       <= 2'd0;
         last_q     <= 2'd3;
         shadow_q   <= 16'h0000;
         step_q     <= 3'd0;
         mismatch_q <= 1'b0;
         gnt_q      <= 4'b0000;
         done_q     <= 4'b0000;
         pass_q     <= 4'b0000;
         solved_q   <= 4'b0000;
         busy_q     <= 1'b0;
         flag_q     <= 16'h0000;
         for (int i = 0; i < 8; i++) begin
            route_q[i] <= 2'b01;
         end
      end else begin
         done_q <= 4'b0000;
         pass_q <= 4'b0000;
         case (state_q)
            S_IDLE: begin
               if (sel_valid_d) begin
                  state_q <= S_GRANT;
                  id_q    <= sel_id_d;
                  gnt_q   <= 4'b0001 << sel_id_d;
                  busy_q  <= 1'b1;
               end else if (cfg_we) begin
                  route_q[cfg_addr] <= cfg_action;
               end
            end
            S_GRANT: begin
               shadow_q   <= status_bus[{id_q, 4'b0000} +: 16];
               step_q     <= 3'd0;
               mismatch_q <= 1'b0;
               state_q    <= S_SCAN;
            end
            S_SCAN: begin
               mismatch_q <= mismatch_d;
               step_q     <= step_q + 3'd1;
               // Result is registered on the last step so it is visible throughout REPORT.
               if (step_q == 3'd7) begin
                  state_q  <= S_REPORT;
                  gnt_q    <= 4'b0000;
                  done_q   <= id_onehot_d;
                  pass_q   <= mismatch_d ? 4'b0000 : id_onehot_d;
                  solved_q <= solved_d;
                  flag_q   <= (solved_d != 4'b0000) ? FLAG : 16'h0000;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               busy_q     <= 1'b0;
               gnt_q      <= 4'b0000;
               last_q     <= id_q;
               step_q     <= 3'd0;
               mismatch_q <= 1'b0;
            end
         endcase
      end
   end

   assign gnt      = gnt_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign solved   = solved_q;
   assign busy     = busy_q;
   assign flag_led = flag_q;

endmodule

`default_nettype wire

// File: tb/tb_route_arbiter.sv
`default_nettype none
// tb_route_arbiter: directed self-checking bench for route_arbiter.
// Rev 1.0

module tb_route_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] status_bus;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [1:0]  cfg_action;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic [3:0]  pass;
   logic [3:0]  solved;
   logic        busy;
   logic [15:0] flag_led;

   int total = 0;
   int bad   = 0;

   route_arbiter #(.FLAG(16'hF1A6)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .status_bus (status_bus),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_action (cfg_action),
      .gnt        (gnt),
      .done       (done),
      .pass       (pass),
      .solved     (solved),
      .busy       (busy),
      .flag_led   (flag_led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      tick;
      tick;
      rst = 1'b1;
   endtask

   // Runs one transaction; observations are returned for the caller to check.
   task automatic run_txn(input logic [3:0] r, input logic [15:0] st_late,
                          input bit scan_write, input bit drop_req,
                          output logic [3:0] g, output logic [3:0] d,
                          output logic [3:0] p, output logic [3:0] stray);
      req = r;
      tick;
      cfg_we = 1'b0;
      g      = gnt;
      stray  = done;
      for (int c = 2; c <= 9; c++) begin
         if (c == 3) begin
            status_bus[15:0] = st_late;
            if (drop_req) req = 4'b0000;
            if (scan_write) begin
               cfg_we     = 1'b1;
               cfg_addr   = 3'd0;
               cfg_action = 2'b00;
            end
         end
         tick;
         cfg_we = 1'b0;
         stray  = stray | done;
      end
      tick;
      d   = done;
      p   = pass;
      req = 4'b0000;
      tick;
   endtask

   task automatic test_reset;
      do_reset;
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done: got %b want 0000", done); end
      total++; if (pass !== 4'b0000) begin bad++; $display("FAIL reset_pass: got %b want 0000", pass); end
      total++; if (solved !== 4'b0000) begin bad++; $display("FAIL reset_solved: got %b want 0000", solved); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (flag_led !== 16'h0000) begin bad++; $display("FAIL reset_flag: got %h want 0000", flag_led); end
   endtask

   task automatic test_basic;
      status_bus = 64'h0;
      req = 4'b0001;
      tick;
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL basic_gnt_t1: got %b want 0001", gnt); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_t1: got %b want 1", busy); end
      for (int c = 2; c <= 9; c++) begin
         tick;
         total++; if (done !== 4'b0000) begin bad++; $display("FAIL basic_early_done t+%0d: got %b want 0000", c, done); end
      end
      tick;
      total++; if (done !== 4'b0001) begin bad++; $display("FAIL basic_done_t10: got %b want 0001", done); end
      total++; if (pass !== 4'b0001) begin bad++; $display("FAIL basic_pass_t10: got %b want 0001", pass); end
      req = 4'b0000;
      tick;
      total++; if (solved !== 4'b0001) begin bad++; $display("FAIL basic_solved_t11: got %b want 0001", solved); end
      total++; if (flag_led !== 16'hF1A6) begin bad++; $display("FAIL basic_flag_t11: got %h want f1a6", flag_led); end
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL basic_gnt_idle: got %b want 0000", gnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
      total++; if (done !== 4'b0000) begin bad++; $display("FAIL basic_done_t11: got %b want 0000", done); end
   endtask

   task automatic test_route;
      logic [1:0]  rt [8];
      logic [3:0]  g, d, p, s;
      rt[0] = 2'b10; rt[1] = 2'b10; rt[2] = 2'b01; rt[3] = 2'b10;
      rt[4] = 2'b11; rt[5] = 2'b01; rt[6] = 2'b01; rt[7] = 2'b11;
      for (int i = 0; i < 8; i++) begin
         cfg_we     = 1'b1;
         cfg_addr   = 3'(i);
         cfg_action = rt[i];
         tick;
      end
      cfg_we = 1'b0;
      // Status changes after capture must not affect the scan.
      status_bus[15:0] = 16'h5182;
      run_txn(4'b0001, 16'h5183, 1'b0, 1'b0, g, d, p, s);
      total++; if (d !== 4'b0001) begin bad++; $display("FAIL route_match_done: got %b want 0001", d); end
      total++; if (p !== 4'b0001) begin bad++; $display("FAIL route_match_pass: got %b want 0001", p); end
      status_bus[15:0] = 16'h5183;
      run_txn(4'b0001, 16'h5183, 1'b0, 1'b0, g, d, p, s);
      total++; if (d !== 4'b0001) begin bad++; $display("FAIL route_miss_done: got %b want 0001", d); end
      total++; if (p !== 4'b0000) begin bad++; $display("FAIL route_miss_pass: got %b want 0000", p); end
      total++; if (solved !== 4'b0001) begin bad++; $display("FAIL route_miss_solved: got %b want 0001", solved); end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp;
      do_reset;
      status_bus = 64'h0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp = 4'b0001 << (k % 4);
         tick;
         total++; if (gnt !== exp) begin bad++; $display("FAIL rr_gnt k=%0d: got %b want %b", k, gnt, exp); end
         for (int c = 2; c <= 10; c++) tick;
         total++; if (done !== exp) begin bad++; $display("FAIL rr_done k=%0d: got %b want %b", k, done, exp); end
         total++; if (pass !== exp) begin bad++; $display("FAIL rr_pass k=%0d: got %b want %b", k, pass, exp); end
         tick;
         total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_gnt_idle k=%0d: got %b want 0000", k, gnt); end
         if (k == 4) req = 4'b0000;
      end
      total++; if (solved !== 4'b1111) begin bad++; $display("FAIL rr_solved: got %b want 1111", solved); end
   endtask

   task automatic test_cfg;
      logic [3:0] g, d, p, s;
      do_reset;
      status_bus = 64'h0;
      // Write in the same IDLE cycle as a grant is dropped.
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_action = 2'b00;
      run_txn(4'b0001, 16'h0000, 1'b0, 1'b0, g, d, p, s);
      total++; if (g !== 4'b0001) begin bad++; $display("FAIL cfg_same_gnt: got %b want 0001", g); end
      total++; if (p !== 4'b0001) begin bad++; $display("FAIL cfg_same_pass: got %b want 0001", p); end
      run_txn(4'b0001, 16'h0000, 1'b1, 1'b0, g, d, p, s);
      total++; if (p !== 4'b0001) begin bad++; $display("FAIL cfg_scan_pass: got %b want 0001", p); end
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_action = 2'b00;
      tick;
      cfg_we = 1'b0;
      run_txn(4'b0001, 16'h0000, 1'b0, 1'b0, g, d, p, s);
      total++; if (d !== 4'b0001) begin bad++; $display("FAIL cfg_idle_done: got %b want 0001", d); end
      total++; if (p !== 4'b0000) begin bad++; $display("FAIL cfg_idle_pass: got %b want 0000", p); end
   endtask

   task automatic test_reset_mid;
      logic [3:0] g, d, p, s;
      logic [3:0] seen;
      do_reset;
      status_bus = 64'h0;
      req = 4'b0001;
      tick;
      for (int c = 2; c <= 6; c++) tick;
      rst = 1'b0;
      tick;
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL mid_gnt: got %b want 0000", gnt); end
      total++; if (done !== 4'b0000) begin bad++; $display("FAIL mid_done: got %b want 0000", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
      total++; if (solved !== 4'b0000) begin bad++; $display("FAIL mid_solved: got %b want 0000", solved); end
      total++; if (flag_led !== 16'h0000) begin bad++; $display("FAIL mid_flag: got %h want 0000", flag_led); end
      rst = 1'b1;
      // Re-served after reset; req dropped mid-scan still yields a report.
      run_txn(4'b0001, 16'h0000, 1'b0, 1'b1, g, d, p, s);
      seen = s;
      total++; if (g !== 4'b0001) begin bad++; $display("FAIL mid_regrant: got %b want 0001", g); end
      total++; if (seen !== 4'b0000) begin bad++; $display("FAIL mid_stray_done: got %b want 0000", seen); end
      total++; if (d !== 4'b0001) begin bad++; $display("FAIL mid_redone: got %b want 0001", d); end
      total++; if (p !== 4'b0001) begin bad++; $display("FAIL mid_repass: got %b want 0001", p); end
      total++; if (solved !== 4'b0001) begin bad++; $display("FAIL mid_resolved: got %b want 0001", solved); end
   endtask

   initial begin
      rst        = 1'b1;
      req        = 4'b0000;
      status_bus = 64'h0;
      cfg_we     = 1'b0;
      cfg_addr   = 3'd0;
      cfg_action = 2'b00;
      test_reset;
      test_basic;
      test_route;
      test_round_robin;
      test_cfg;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
